// File: rtl/sonic_tx_gearbox_66to40.sv
// 64b/66b transmit gearbox: optional self-synchronous payload scrambling, then
// packing of 66-bit blocks into a continuous 40-bit transceiver word stream.
module sonic_tx_gearbox_66to40 #(
  parameter bit          SCRAMBLE = 1'b1,
  parameter logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        pld_clk,
  input  logic        local_rstn,
  input  logic [65:0] in_block,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [39:0] tx_data,
  output logic        tx_valid,
  output logic [6:0]  fill_level,
  output logic [15:0] underrun_cnt,
  output logic [15:0] hdr_err_cnt
);
  localparam int unsigned BUF_W = 106;

  logic [BUF_W-1:0] r_buf;
  logic [6:0]       r_fill;
  logic [39:0]      r_tx_data;
  logic             r_tx_valid;
  logic             r_primed;
  logic [15:0]      r_urun;
  logic [15:0]      r_herr;
  logic [57:0]      r_scr;

  logic             w_out;
  logic             w_acc;
  logic             w_hdr_bad;
  logic [6:0]       w_fill_after;
  logic [6:0]       w_fill_nxt;
  logic [65:0]      w_blk;
  logic [57:0]      w_scr_nxt;
  logic [BUF_W-1:0] w_buf_nxt;

  assign w_out        = (r_fill >= 7'd40);
  assign w_fill_after = w_out ? (r_fill - 7'd40) : r_fill;
  assign in_ready     = (w_fill_after <= 7'd40);
  assign w_acc        = in_valid & in_ready;
  assign w_hdr_bad    = (in_block[1] == in_block[0]);
  assign w_fill_nxt   = w_acc ? (w_fill_after + 7'd66) : w_fill_after;

  // ext[57:0] is the history (ext[57] newest); ext[58+i] is scrambled bit i.
  always_comb begin : scrambler
    logic [121:0] ext;
    ext = {64'b0, r_scr};
    for (int i = 0; i < 64; i++)
      ext[58+i] = in_block[2+i] ^ ext[19+i] ^ ext[i];
    w_scr_nxt = ext[121:64];
    w_blk     = SCRAMBLE ? {ext[121:58], in_block[1:0]} : in_block;
  end

  // Bits above fill are always zero, so the new block can simply be OR-ed in.
  always_comb begin
    w_buf_nxt = w_out ? (r_buf >> 40) : r_buf;
    if (w_acc)
      w_buf_nxt = w_buf_nxt | ({40'b0, w_blk} << w_fill_after);
  end

  always_ff @(posedge pld_clk or negedge local_rstn) begin
    if (!local_rstn) begin
      r_buf      <= '0;
      r_fill     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_primed   <= 1'b0;
      r_urun     <= '0;
      r_herr     <= '0;
      r_scr      <= SCR_SEED;
    end else begin
      r_buf      <= w_buf_nxt;
      r_fill     <= w_fill_nxt;
      r_tx_data  <= w_out ? r_buf[39:0] : 40'b0;
      r_tx_valid <= w_out;
      if (w_out)
        r_primed <= 1'b1;
      if (r_primed && !w_out && (r_urun != 16'hFFFF))
        r_urun <= r_urun + 16'd1;
      if (w_acc && w_hdr_bad && (r_herr != 16'hFFFF))
        r_herr <= r_herr + 16'd1;
      if (w_acc && SCRAMBLE)
        r_scr <= w_scr_nxt;
    end
  end

  assign tx_data      = r_tx_data;
  assign tx_valid     = r_tx_valid;
  assign fill_level   = r_fill;
  assign underrun_cnt = r_urun;
  assign hdr_err_cnt  = r_herr;

endmodule

// File: tb/tb_sonic_tx_gearbox_66to40.sv
// Bench for sonic_tx_gearbox_66to40: a plain and a scrambling (seed 0) instance
// share stimulus and are compared against a bit-queue stream model.
module tb_sonic_tx_gearbox_66to40;
  logic        pld_clk = 1'b0;
  logic        local_rstn;
  logic [65:0] in_block;
  logic        in_valid;
  logic        rdy_a, rdy_b, txv_a, txv_b;
  logic [39:0] txd_a, txd_b;
  logic [6:0]  fill_a, fill_b;
  logic [15:0] urun_a, urun_b, herr_a, herr_b;

  always #5 pld_clk = ~pld_clk;

  sonic_tx_gearbox_66to40 #(.SCRAMBLE(1'b0)) u_plain (
    .pld_clk(pld_clk), .local_rstn(local_rstn), .in_block(in_block), .in_valid(in_valid),
    .in_ready(rdy_a), .tx_data(txd_a), .tx_valid(txv_a), .fill_level(fill_a),
    .underrun_cnt(urun_a), .hdr_err_cnt(herr_a));

  sonic_tx_gearbox_66to40 #(.SCRAMBLE(1'b1), .SCR_SEED(58'h0)) u_scr (
    .pld_clk(pld_clk), .local_rstn(local_rstn), .in_block(in_block), .in_valid(in_valid),
    .in_ready(rdy_b), .tx_data(txd_b), .tx_valid(txv_b), .fill_level(fill_b),
    .underrun_cnt(urun_b), .hdr_err_cnt(herr_b));

  int nvec = 0;
  int nerr = 0;

  // Reference: the outgoing bitstreams as queues, oldest bit at the front.
  bit          qa[$], qb[$], hist[$];
  logic [39:0] m_txa, m_txb;
  logic        m_txv, m_primed, m_acc;
  int          m_urun, m_herr;
  int          words_a;
  logic        last_rdy;
  logic [39:0] capb[$];

  typedef struct {
    logic       v;
    logic [1:0] hdr;
    logic       rdy;
    int         fill;
    logic       txv;
    int         herr;
  } hvec_t;
  hvec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete(); hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b0);
    m_txa = '0; m_txb = '0; m_txv = 1'b0; m_primed = 1'b0; m_acc = 1'b0;
    m_urun = 0; m_herr = 0;
  endtask

  task automatic model_edge(input logic v, input logic [65:0] b);
    int f, fa;
    bit s;
    f  = qa.size();
    fa = (f >= 40) ? f - 40 : f;
    m_acc = v && (fa <= 40);
    if (f >= 40) begin
      for (int i = 0; i < 40; i++) begin
        m_txa[i] = qa.pop_front();
        m_txb[i] = qb.pop_front();
      end
      m_txv = 1'b1;
    end else begin
      m_txa = '0; m_txb = '0; m_txv = 1'b0;
      if (m_primed && m_urun < 65535) m_urun++;
    end
    if (f >= 40) m_primed = 1'b1;
    if (m_acc) begin
      if (b[1] == b[0] && m_herr < 65535) m_herr++;
      for (int i = 0; i < 2; i++) begin qa.push_back(b[i]); qb.push_back(b[i]); end
      // hist[19] is S[n-39], hist[0] is S[n-58]
      for (int i = 0; i < 64; i++) begin
        s = b[2+i] ^ hist[19] ^ hist[0];
        void'(hist.pop_front());
        hist.push_back(s);
        qa.push_back(b[2+i]);
        qb.push_back(s);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [65:0] b);
    int f, fa;
    in_valid = v;
    in_block = b;
    @(negedge pld_clk);
    f  = qa.size();
    fa = (f >= 40) ? f - 40 : f;
    last_rdy = rdy_a;
    chk("in_ready_a", 64'(rdy_a), 64'(fa <= 40));
    chk("in_ready_b", 64'(rdy_b), 64'(fa <= 40));
    chk("fill_a", 64'(fill_a), 64'(f));
    chk("fill_b", 64'(fill_b), 64'(f));
    chk("tx_valid_a", 64'(txv_a), 64'(m_txv));
    chk("tx_valid_b", 64'(txv_b), 64'(m_txv));
    chk("tx_data_a", 64'(txd_a), 64'(m_txa));
    chk("tx_data_b", 64'(txd_b), 64'(m_txb));
    chk("underrun_a", 64'(urun_a), 64'(m_urun));
    chk("underrun_b", 64'(urun_b), 64'(m_urun));
    chk("hdr_err_a", 64'(herr_a), 64'(m_herr));
    chk("hdr_err_b", 64'(herr_b), 64'(m_herr));
    if (txv_a) words_a++;
    if (txv_b) capb.push_back(txd_b);
    model_edge(v, b);
    @(posedge pld_clk);
    #1;
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock.
  task automatic rst_pulse();
    in_valid = 1'b0;
    in_block = '0;
    #3 local_rstn = 1'b0;
    #1;
    chk("rst_tx_valid", 64'({txv_a, txv_b}), 64'd0);
    chk("rst_tx_data_a", 64'(txd_a), 64'd0);
    chk("rst_tx_data_b", 64'(txd_b), 64'd0);
    chk("rst_fill", 64'({fill_a, fill_b}), 64'd0);
    chk("rst_counters", 64'({urun_a, herr_a, urun_b, herr_b}), 64'd0);
    chk("rst_in_ready", 64'({rdy_a, rdy_b}), 64'd3);
    #1 local_rstn = 1'b1;
    model_reset();
    @(posedge pld_clk);
    #1;
    model_edge(1'b0, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent, idx, low, dens;
    logic        pend;
    logic [65:0] rb;

    tbl[0] = '{1'b1, 2'b00, 1'b1, 66,  1'b0, 1};
    tbl[1] = '{1'b1, 2'b01, 1'b1, 92,  1'b1, 1};
    tbl[2] = '{1'b1, 2'b11, 1'b0, 52,  1'b1, 1};
    tbl[3] = '{1'b1, 2'b11, 1'b1, 78,  1'b1, 2};
    tbl[4] = '{1'b1, 2'b10, 1'b1, 104, 1'b1, 2};
    tbl[5] = '{1'b0, 2'b00, 1'b0, 64,  1'b1, 2};
    tbl[6] = '{1'b0, 2'b00, 1'b1, 24,  1'b1, 2};
    tbl[7] = '{1'b0, 2'b00, 1'b1, 24,  1'b0, 2};

    local_rstn = 1'b1;
    in_valid   = 1'b0;
    in_block   = '0;
    model_reset();
    @(posedge pld_clk);
    #1;
    rst_pulse();

    // Header checks and fill/handshake timing from an empty buffer
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].v, {64'hC3C3_0F0F_9696_1234, tbl[i].hdr});
      chk("tbl_in_ready", 64'(last_rdy), 64'(tbl[i].rdy));
      chk("tbl_fill", 64'(fill_a), 64'(tbl[i].fill));
      chk("tbl_tx_valid", 64'(txv_a), 64'(tbl[i].txv));
      chk("tbl_hdr_err", 64'(herr_a), 64'(tbl[i].herr));
    end

    // Underrun, then counter saturation, then resume
    rst_pulse();
    words_a = 0;
    sent = 0;
    for (int c = 0; c < 20 && sent < 3; c++) begin
      cyc(1'b1, {32'h0, 32'(sent), 2'b10});
      if (m_acc) sent++;
    end
    repeat (10) cyc(1'b0, '0);
    chk("urun_fill", 64'(fill_a), 64'd38);
    chk("urun_words", 64'(words_a), 64'd4);
    chk("urun_tx_valid", 64'(txv_a), 64'd0);
    chk("urun_count", 64'(urun_a), 64'd9);
    repeat (65534 - m_urun) @(posedge pld_clk);
    #1;
    chk("urun_fffe", 64'(urun_a), 64'hFFFE);
    repeat (2) @(posedge pld_clk);
    #1;
    chk("urun_sat", 64'(urun_a), 64'hFFFF);
    chk("urun_sat_b", 64'(urun_b), 64'hFFFF);
    m_urun = 65535;
    sent = 0;
    for (int c = 0; c < 20 && sent < 3; c++) begin
      cyc(1'b1, {32'hFACE_0000, 32'(sent), 2'b01});
      if (m_acc) sent++;
    end
    repeat (8) cyc(1'b0, '0);

    // Continuous packing of 40 blocks, SCRAMBLE=0 stream checked by model
    rst_pulse();
    words_a = 0;
    idx = 0;
    low = 0;
    for (int c = 0; c < 200 && idx < 40; c++) begin
      cyc(1'b1, {32'(idx), 32'hA5A5_5A5A, 2'b01});
      if (c >= 1 && c <= 33 && !last_rdy) low++;
      if (m_acc) idx++;
    end
    repeat (6) cyc(1'b0, '0);
    chk("pack_blocks", 64'(idx), 64'd40);
    chk("pack_words", 64'(words_a), 64'd66);
    chk("pack_fill_end", 64'(fill_a), 64'd0);
    chk("pack_ready_low", 64'(low), 64'd13);

    // Randomised traffic with bursts and idle phases
    rst_pulse();
    pend = 1'b0;
    dens = 2;
    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) dens = $urandom_range(0, 4);
      if (!pend && $urandom_range(0, 3) < dens) begin
        pend = 1'b1;
        rb = {$urandom(), $urandom(), 2'($urandom_range(0, 3))};
      end
      cyc(pend, rb);
      if (m_acc) pend = 1'b0;
    end

    // Reset at fill 92 then scrambler impulse response from seed 0
    rst_pulse();
    cyc(1'b1, {64'h1234_5678_9ABC_DEF0, 2'b01});
    cyc(1'b1, {64'h0FED_CBA9_8765_4321, 2'b10});
    chk("mid_fill", 64'(fill_a), 64'd92);
    rst_pulse();
    capb.delete();
    sent = 0;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      cyc(1'b1, {63'b0, 1'(sent == 0), 2'b01});
      if (m_acc) sent++;
    end
    repeat (6) cyc(1'b0, '0);
    chk("scr_words", 64'(capb.size()), 64'd6);
    chk("scr_word0", 64'(capb[0]), 64'h00_0000_0005);
    chk("scr_word1", 64'(capb[1]), 64'h00_0410_0002);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
